// File: rtl/mcp3008_emu.sv
// SPI responder that behaves like an MCP3008 10-bit ADC.
// It returns per-channel values from chan_data, in single-ended or differential mode.
module mcp3008_emu #(
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLK50,
  input  logic            reset_n,
  input  logic            sclk,
  input  logic            cs_n,
  input  logic            mosi,
  input  logic [7:0][9:0] chan_data,
  output logic            miso,
  output logic            miso_oe,
  output logic [2:0]      conv_chan,
  output logic            conv_sgl,
  output logic            conv_valid,
  output logic            frame_err
);

  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_START = 3'd1,
    CMD        = 3'd2,
    SAMPLE     = 3'd3,
    DATA       = 3'd4,
    DONE       = 3'd5
  } state_t;

  state_t      state_r, state_n;
  logic [SS-1:0] sclk_sync_r, cs_sync_r, mosi_sync_r;
  logic        sclk_d_r, cs_d_r;
  logic [SS:0] ready_r;
  logic [3:0]  cnt_r, cnt_n;
  logic [2:0]  cmd_r, cmd_n;
  logic [9:0]  result_r, result_n;
  logic        rise_seen_r, rise_seen_n;
  logic        miso_n, oe_n, sgl_n, valid_n, err_n;
  logic [2:0]  chan_n;

  logic        sclk_s, cs_s, mosi_s, ready_s;
  logic        sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s;
  logic [3:0]  cmd_full_s;
  logic [10:0] diff_s;
  logic [9:0]  conv_res_s;

  assign sclk_s  = sclk_sync_r[SS-1];
  assign cs_s    = cs_sync_r[SS-1];
  assign mosi_s  = mosi_sync_r[SS-1];
  // Edges are trusted only once the synchronizers hold real pin samples after reset,
  // so a cs_n held low across reset release is never mistaken for a fresh frame.
  assign ready_s     = ready_r[SS];
  assign sclk_rise_s = ready_s & sclk_s & ~sclk_d_r;
  assign sclk_fall_s = ready_s & ~sclk_s & sclk_d_r;
  assign cs_rise_s   = ready_s & cs_s & ~cs_d_r;
  assign cs_fall_s   = ready_s & ~cs_s & cs_d_r;

  assign cmd_full_s = {cmd_r, mosi_s};
  assign diff_s = {1'b0, chan_data[cmd_full_s[2:0]]} - {1'b0, chan_data[cmd_full_s[2:0] ^ 3'b001]};

  // Conversion result for the command completing on this rise
  always_comb begin
    conv_res_s = 10'd0;
    if (cmd_full_s[3]) begin
      conv_res_s = chan_data[cmd_full_s[2:0]];
    end else if (diff_s[10] || (diff_s == 11'd0)) begin
      conv_res_s = 10'd0;
    end else begin
      conv_res_s = diff_s[9:0];
    end
  end

  // Frame sequencing: next state and next register values
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    cmd_n       = cmd_r;
    result_n    = result_r;
    rise_seen_n = rise_seen_r;
    miso_n      = miso;
    oe_n        = miso_oe;
    chan_n      = conv_chan;
    sgl_n       = conv_sgl;
    valid_n     = 1'b0;
    err_n       = 1'b0;
    if (cs_rise_s) begin
      state_n = IDLE;
      miso_n  = 1'b0;
      oe_n    = 1'b0;
      err_n   = (state_r == CMD) || (state_r == SAMPLE) || (state_r == DATA);
    end else begin
      case (state_r)
        IDLE: begin
          if (cs_fall_s) state_n = WAIT_START;
          else           state_n = IDLE;
        end
        WAIT_START: begin
          if (sclk_rise_s && mosi_s) begin
            state_n = CMD;
            cnt_n   = 4'd0;
          end else begin
            state_n = WAIT_START;
          end
        end
        CMD: begin
          if (sclk_rise_s) begin
            if (cnt_r == 4'd3) begin
              state_n     = SAMPLE;
              chan_n      = cmd_full_s[2:0];
              sgl_n       = cmd_full_s[3];
              valid_n     = 1'b1;
              result_n    = conv_res_s;
              rise_seen_n = 1'b0;
            end else begin
              cmd_n = cmd_full_s[2:0];
              cnt_n = cnt_r + 4'd1;
            end
          end else begin
            state_n = CMD;
          end
        end
        SAMPLE: begin
          if (sclk_rise_s) begin
            rise_seen_n = 1'b1;
          end else if (sclk_fall_s && rise_seen_r) begin
            state_n = DATA;
            miso_n  = 1'b0;
            oe_n    = 1'b1;
            cnt_n   = 4'd0;
          end else begin
            state_n = SAMPLE;
          end
        end
        DATA: begin
          if (sclk_fall_s) begin
            miso_n = result_r[4'd9 - cnt_r];
            oe_n   = 1'b1;
            if (cnt_r == 4'd9) state_n = DONE;
            else               cnt_n   = cnt_r + 4'd1;
          end else begin
            state_n = DATA;
          end
        end
        DONE: begin
          if (sclk_fall_s) begin
            miso_n = 1'b0;
            oe_n   = 1'b1;
          end else begin
            state_n = DONE;
          end
        end
        default: begin
          state_n = IDLE;
          miso_n  = 1'b0;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

  // Synchronizers, edge-detect history and all registered state/outputs
  always_ff @(posedge CLK50 or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_r <= {SS{1'b0}};
      cs_sync_r   <= {SS{1'b1}};
      mosi_sync_r <= {SS{1'b0}};
      sclk_d_r    <= 1'b0;
      cs_d_r      <= 1'b1;
      ready_r     <= {(SS+1){1'b0}};
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      cmd_r       <= 3'd0;
      result_r    <= 10'd0;
      rise_seen_r <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
      conv_chan   <= 3'd0;
      conv_sgl    <= 1'b0;
      conv_valid  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[SS-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[SS-2:0], cs_n};
      mosi_sync_r <= {mosi_sync_r[SS-2:0], mosi};
      sclk_d_r    <= sclk_s;
      cs_d_r      <= cs_s;
      ready_r     <= {ready_r[SS-1:0], 1'b1};
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      cmd_r       <= cmd_n;
      result_r    <= result_n;
      rise_seen_r <= rise_seen_n;
      miso        <= miso_n;
      miso_oe     <= oe_n;
      conv_chan   <= chan_n;
      conv_sgl    <= sgl_n;
      conv_valid  <= valid_n;
      frame_err   <= err_n;
    end
  end

endmodule

// File: tb/tb_mcp3008_emu.sv
// Directed bench for mcp3008_emu: a vector table of complete SPI frames,
// plus hand-written abort, data-stability and mid-frame reset sequences.
module tb_mcp3008_emu;

  localparam int SYNC = 2;
  localparam int HALF = 8;

  logic            CLK50 = 1'b0;
  logic            reset_n = 1'b0;
  logic            sclk = 1'b0;
  logic            cs_n = 1'b1;
  logic            mosi = 1'b0;
  logic [7:0][9:0] chan_data;
  logic            miso, miso_oe, conv_sgl, conv_valid, frame_err;
  logic [2:0]      conv_chan;

  mcp3008_emu #(.SYNC_STAGES(SYNC)) dut (
    .CLK50(CLK50), .reset_n(reset_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .chan_data(chan_data), .miso(miso), .miso_oe(miso_oe), .conv_chan(conv_chan),
    .conv_sgl(conv_sgl), .conv_valid(conv_valid), .frame_err(frame_err)
  );

  always #10 CLK50 = ~CLK50;

  int n_vec = 0;
  int n_err = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int oe_cnt = 0;
  logic [31:0] rx;

  always @(posedge CLK50) begin
    if (conv_valid) cv_cnt <= cv_cnt + 1;
    if (frame_err)  fe_cnt <= fe_cnt + 1;
    if (miso_oe)    oe_cnt <= oe_cnt + 1;
  end

  typedef struct {
    logic [31:0]     tx;
    int              nbits;
    logic [7:0][9:0] cd;
    logic [9:0]      exp_res;
    logic [2:0]      exp_chan;
    logic            exp_sgl;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cs_low();
    @(negedge CLK50);
    cs_n = 1'b0;
    rx   = 32'd0;
    repeat (HALF) @(negedge CLK50);
  endtask

  // Mode-0 initiator: set mosi while sclk low, sample miso just before each rise
  task automatic run_clocks(input logic [31:0] tx, input int nbits, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      sclk = 1'b0;
      mosi = tx[nbits - k];
      repeat (HALF) @(negedge CLK50);
      rx = {rx[30:0], miso};
      sclk = 1'b1;
      repeat (HALF) @(negedge CLK50);
    end
  endtask

  task automatic end_frame();
    sclk = 1'b0;
    repeat (HALF) @(negedge CLK50);
    cs_n = 1'b1;
    mosi = 1'b0;
    repeat (HALF) @(negedge CLK50);
  endtask

  logic [7:0][9:0] base;
  int cv0, fe0, oe0;
  bit seen;

  initial begin
    base[0] = 10'h155; base[1] = 10'h2A5; base[2] = 10'h300; base[3] = 10'h100;
    base[4] = 10'h050; base[5] = 10'h060; base[6] = 10'h3FF; base[7] = 10'h3FF;
    for (int i = 0; i < 10; i++) begin
      vecs[i].cd = base;
      vecs[i].nbits = 24;
    end
    vecs[0].tx = 32'h019000; vecs[0].exp_res = 10'h2A5; vecs[0].exp_chan = 3'd1; vecs[0].exp_sgl = 1'b1;
    vecs[1].tx = 32'h012000; vecs[1].exp_res = 10'h200; vecs[1].exp_chan = 3'd2; vecs[1].exp_sgl = 1'b0;
    vecs[2].tx = 32'h012000; vecs[2].exp_res = 10'h000; vecs[2].exp_chan = 3'd2; vecs[2].exp_sgl = 1'b0;
    vecs[2].cd[2] = 10'h100; vecs[2].cd[3] = 10'h300;
    vecs[3].tx = 32'h013000; vecs[3].exp_res = 10'h000; vecs[3].exp_chan = 3'd3; vecs[3].exp_sgl = 1'b0;
    vecs[4].tx = 32'h015000; vecs[4].exp_res = 10'h010; vecs[4].exp_chan = 3'd5; vecs[4].exp_sgl = 1'b0;
    vecs[5].tx = 32'h016000; vecs[5].exp_res = 10'h000; vecs[5].exp_chan = 3'd6; vecs[5].exp_sgl = 1'b0;
    vecs[6].tx = 32'h01F000; vecs[6].exp_res = 10'h3FF; vecs[6].exp_chan = 3'd7; vecs[6].exp_sgl = 1'b1;
    vecs[7].tx = 32'h018000; vecs[7].exp_res = 10'h155; vecs[7].exp_chan = 3'd0; vecs[7].exp_sgl = 1'b1;
    vecs[8].tx = 32'h019000; vecs[8].exp_res = 10'h2A5; vecs[8].exp_chan = 3'd1; vecs[8].exp_sgl = 1'b1;
    vecs[8].nbits = 27;
    vecs[9].tx = 32'h014000; vecs[9].exp_res = 10'h000; vecs[9].exp_chan = 3'd4; vecs[9].exp_sgl = 1'b0;

    chan_data = base;
    repeat (5) @(negedge CLK50);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_chan", {29'd0, conv_chan}, 32'd0);
    check("rst_sgl", {31'd0, conv_sgl}, 32'd0);
    check("rst_valid", {31'd0, conv_valid}, 32'd0);
    check("rst_err", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    repeat (8) @(negedge CLK50);

    for (int i = 0; i < 10; i++) begin
      chan_data = vecs[i].cd;
      cv0 = cv_cnt; fe0 = fe_cnt; oe0 = oe_cnt;
      cs_low();
      run_clocks(vecs[i].tx, vecs[i].nbits, 1, vecs[i].nbits);
      end_frame();
      check($sformatf("v%0d_result", i), {22'd0, rx[9:0]}, {22'd0, vecs[i].exp_res});
      check($sformatf("v%0d_null", i), {31'd0, rx[10]}, 32'd0);
      check($sformatf("v%0d_lead", i), rx >> 11, 32'd0);
      check($sformatf("v%0d_chan", i), {29'd0, conv_chan}, {29'd0, vecs[i].exp_chan});
      check($sformatf("v%0d_sgl", i), {31'd0, conv_sgl}, {31'd0, vecs[i].exp_sgl});
      check($sformatf("v%0d_valid_pulses", i), cv_cnt - cv0, 32'd1);
      check($sformatf("v%0d_frame_err", i), fe_cnt - fe0, 32'd0);
      check($sformatf("v%0d_oe_used", i), {31'd0, (oe_cnt - oe0) > 0}, 32'd1);
      check($sformatf("v%0d_oe_after", i), {31'd0, miso_oe}, 32'd0);
    end

    // Abort after rise S+7 (clock 15), then a clean channel-7 frame
    chan_data = base;
    fe0 = fe_cnt;
    cs_low();
    run_clocks(32'h019000, 24, 1, 15);
    check("abort_oe_before", {31'd0, miso_oe}, 32'd1);
    cs_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < SYNC + 2; c++) begin
      @(negedge CLK50);
      if (!miso_oe && !seen) seen = 1'b1;
    end
    check("abort_oe_fall", {31'd0, seen}, 32'd1);
    check("abort_miso", {31'd0, miso}, 32'd0);
    sclk = 1'b0;
    repeat (HALF) @(negedge CLK50);
    check("abort_err_pulses", fe_cnt - fe0, 32'd1);
    fe0 = fe_cnt;
    cs_low();
    run_clocks(32'h01F000, 24, 1, 24);
    end_frame();
    check("after_abort_result", {21'd0, rx[10:0]}, 32'h3FF);
    check("after_abort_err", fe_cnt - fe0, 32'd0);

    // chan_data changing during DATA must not affect the frame in flight
    chan_data = base;
    cs_low();
    run_clocks(32'h019000, 24, 1, 16);
    chan_data[1] = 10'h000;
    run_clocks(32'h019000, 24, 17, 24);
    end_frame();
    check("stable_result", {21'd0, rx[10:0]}, 32'h2A5);

    // Reset at rise S+8, then a full command with cs_n still low is ignored
    chan_data = base;
    cs_low();
    run_clocks(32'h019000, 24, 1, 16);
    check("pre_rst_chan", {29'd0, conv_chan}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
    check("mid_rst_miso", {31'd0, miso}, 32'd0);
    check("mid_rst_chan", {29'd0, conv_chan}, 32'd0);
    check("mid_rst_sgl", {31'd0, conv_sgl}, 32'd0);
    repeat (4) @(negedge CLK50);
    reset_n = 1'b1;
    repeat (4) @(negedge CLK50);
    cv0 = cv_cnt; oe0 = oe_cnt;
    rx = 32'd0;
    run_clocks(32'h019000, 24, 1, 24);
    end_frame();
    check("post_rst_no_valid", cv_cnt - cv0, 32'd0);
    check("post_rst_no_oe", oe_cnt - oe0, 32'd0);
    check("post_rst_rx", rx, 32'd0);
    cs_low();
    run_clocks(32'h019000, 24, 1, 24);
    end_frame();
    check("fresh_result", {21'd0, rx[10:0]}, 32'h2A5);
    check("fresh_chan", {29'd0, conv_chan}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mcp3008_emu.md
MCP3008_EMU -- requirements
Module: mcp3008_emu

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth on sclk, cs_n and mosi (minimum 2).
REQ-002 SHALL have port CLK50  input  1  system clock, the only clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port sclk  input  1  SPI clock from the initiator, asynchronous to CLK50.
REQ-005 SHALL have port cs_n  input  1  SPI chip select, active low.
REQ-006 SHALL have port mosi  input  1  initiator-to-responder serial data.
REQ-007 SHALL have port chan_data  input  8x10  per-channel ADC value returned to the initiator.
REQ-008 SHALL have port miso  output  1  responder-to-initiator serial data.
REQ-009 SHALL have port miso_oe  output  1  output enable for the external miso tristate.
REQ-010 SHALL have port conv_chan  output  3  channel selected by the last decoded command.
REQ-011 SHALL have port conv_sgl  output  1  SGL/DIFF bit of the last decoded command.
REQ-012 SHALL have port conv_valid  output  1  one-cycle pulse when a command is decoded.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse when a frame aborts early.

Function
REQ-014 SHALL sample sclk, cs_n and mosi through SYNC_STAGES flip-flops, then detect sclk rise and fall by comparing the last stage with one extra register.
REQ-015 SHALL support sclk high and low phases of at least 4 CLK50 cycles each; behaviour at faster sclk is undefined.
REQ-016 SHALL implement states IDLE, WAIT_START, CMD, SAMPLE, DATA and DONE.
REQ-017 SHALL stay in IDLE while synchronized cs_n is high, and move to WAIT_START on its falling edge.
REQ-018 SHALL, in WAIT_START, ignore mosi=0 on sclk rises and move to CMD on the first sclk rise with mosi=1 (start bit, rise S).
REQ-019 SHALL, in CMD, shift mosi on rises S+1..S+4 into SGL, D2, D1 and D0, MSB first.
REQ-020 SHALL, on rise S+4, update conv_chan and conv_sgl, pulse conv_valid for one cycle, latch the 10-bit result and enter SAMPLE.
REQ-021 SHALL compute the result as chan_data[D2:D0] when SGL=1.
REQ-022 SHALL, when SGL=0, compute the result as chan_data[ch] minus chan_data[ch^1], clamped to 0 when the difference is zero or negative, using 11-bit intermediate arithmetic.
REQ-023 SHALL, on the fall following rise S+5, drive miso=0 (null bit), assert miso_oe and enter DATA.
REQ-024 SHALL, in DATA, drive result bits B9..B0 MSB first on the falls following rises S+6..S+15.
REQ-025 SHALL enter DONE after B0 is driven, and drive miso=0 with miso_oe held high on any further falls while cs_n stays low.
REQ-026 SHALL update miso no later than 1 CLK50 cycle after the internally detected sclk fall, so the total pin-to-pin delay is at most SYNC_STAGES+2 cycles.
REQ-027 SHALL, on synchronized cs_n rise in any state, deassert miso_oe and drive miso=0 in the same cycle and return to IDLE.
REQ-028 SHALL pulse frame_err if that cs_n rise occurs in CMD, SAMPLE or DATA; a rise in WAIT_START or DONE SHALL NOT pulse frame_err.
REQ-029 SHALL hold miso_oe low in IDLE, WAIT_START, CMD and SAMPLE.
REQ-030 SHALL sample chan_data only at rise S+4, so later chan_data changes do not affect the frame in progress.
REQ-031 SHALL give priority to cs_n rise when it coincides with an sclk edge in the same cycle, ignoring that edge.

Reset
REQ-032 SHALL, while reset_n is low, asynchronously set state=IDLE, miso=0, miso_oe=0, conv_chan=0, conv_sgl=0, conv_valid=0, frame_err=0 and all synchronizers to idle levels (sclk=0, cs_n=1, mosi=0).
REQ-033 SHALL, after reset is released mid-frame, ignore the rest of the frame until cs_n goes high and then low again.

Verification
REQ-034 Single-ended read: chan_data[1]=0x2A5, initiator sends 0x01,0x90,0x00 with 24 clocks -> byte1 low bits null=0,B9=1,B8=0; byte2=0xA5; conv_chan=1, conv_sgl=1, one conv_valid pulse.
REQ-035 Differential read: chan_data[2]=0x300, chan_data[3]=0x100, bytes 0x01,0x20,0x00 -> result 0x200; swapping the two values -> result 0x000.
REQ-036 Leading zeros: 3 extra low bits before the start bit (bytes shifted accordingly) -> same result as REQ-034, with result timing relative to the start bit.
REQ-037 Abort: cs_n rises after rise S+7 -> miso_oe falls within SYNC_STAGES+2 cycles, one frame_err pulse; the next full frame for channel 7 (0x3FF) returns 0x3FF.
REQ-038 Stability: chan_data[1] changes from 0x2A5 to 0x000 during DATA -> the initiator still receives 0x2A5.
REQ-039 Reset mid-frame: assert reset_n at rise S+8 -> all outputs reach reset values immediately; no response until a fresh cs_n low.
